risc_v_multicycle_core: RTL and testbench
=========================================

RISC_V_MULTICYCLE_CORE -- requirements
Module: riscv_multicycle_core

Interface
REQ-001 Parameter XLEN, 64, datapath and register width; legal values 32 or 64.
REQ-002 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port mem_req  output  1  memory request valid.
REQ-006 Port mem_we  output  1  1 = store, 0 = read; meaningful only while mem_req=1.
REQ-007 Port mem_addr  output  XLEN  byte address.
REQ-008 Port mem_wdata  output  XLEN  store data.
REQ-009 Port mem_rdata  input  XLEN  read data; valid in the cycle mem_ready=1.
REQ-010 Port mem_ready  input  1  memory accepts or completes the request this cycle.
REQ-011 Port retire  output  1  one-cycle pulse per completed instruction.
REQ-012 Port halted  output  1  core stopped on an illegal instruction.
REQ-013 Port pc_out  output  XLEN  PC of the current instruction.
REQ-014 Port cycle_cnt, instret_cnt  output  64 each  performance counters (see Configuration).

Function
REQ-015 Supported instructions: add, sub, and, or (0110011); addi (0010011); ld/lw (0000011, funct3 011/010 for XLEN 64/32); sd/sw (0100011, same funct3 rule); beq, bne, blt, bge (1100011). All other encodings are illegal.
REQ-016 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT. Transitions: FETCH->DECODE on mem_ready; DECODE->EXEC; EXEC->FETCH for branches; EXEC->MEM for loads/stores; EXEC->WB for R-type/addi; MEM->WB (load) or MEM->FETCH (store) on mem_ready; WB->FETCH. DECODE->HALT on illegal opcode.
REQ-017 Zero-wait latency: branch 3 cycles, R-type/addi 4, store 4, load 5; each mem_ready=0 cycle adds one cycle.
REQ-018 Handshake: mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the edge sampling mem_ready=1; mem_req=0 in DECODE, EXEC, WB and HALT; mem_ready while mem_req=0 is ignored.
REQ-019 FETCH: mem_addr=PC, mem_we=0; IR latches mem_rdata on mem_ready.
REQ-020 Immediate: sign-extended to XLEN; branch offset = imm<<1 (B-format), taken target = PC+offset, else PC+4; PC wraps modulo 2^XLEN.
REQ-021 blt/bge use signed comparison; sub is two's-complement, overflow ignored.
REQ-022 Register file: 32 x XLEN, two read ports, one write port written only in WB; writes to x0 are discarded and x0 reads 0.
REQ-023 retire pulses in the final cycle of each instruction (EXEC for branches, MEM for stores, WB otherwise); PC updates on the same edge.
REQ-024 HALT is terminal: halted=1, retire=0, no memory requests, PC frozen, until reset.
REQ-025 mem_addr is not checked for alignment; misaligned accesses are issued unchanged.

Reset
REQ-026 reset=0 immediately forces: state=FETCH, PC=RESET_PC, IR=0, all registers=0, mem_req=0, retire=0, halted=0, counters=0.
REQ-027 Reset asserted mid-transaction abandons the request; after release, mem_req rises in the first cycle with mem_addr=RESET_PC.

Configuration
REQ-028 Macro RISCV_MC_PERF_CNT_EN defined: cycle_cnt increments every non-reset cycle, including HALT; instret_cnt increments on each retire; both wrap at 2^64.
REQ-029 Macro undefined: cycle_cnt and instret_cnt are constant 0 and no counter flops are inferred.

Structure
REQ-030 Package riscv_mc_pkg holds the opcode/funct3 constants, FSM state enumeration and ALU operation encoding.
REQ-031 Sub-module mc_regfile (parametrised by XLEN) implements the register file; ALU, immediate generation and FSM stay in the top module.

Verification
REQ-032 Hold reset=0 for 3 cycles, then release -> mem_req=0, pc_out=0 during reset; mem_req=1, mem_addr=0, mem_we=0 in the first cycle after release.
REQ-033 Run addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sd x3,8(x0) -> store with mem_addr=8, mem_wdata=12, mem_we=1; 4 retire pulses.
REQ-034 ld x4,8(x0) with mem_ready delayed 3 cycles in MEM -> request signals stable throughout; x4=12; 8 cycles total to retire.
REQ-035 At PC=0x20, beq x1,x1,-8 -> next fetch at 0x18; bne x1,x1,-8 -> next fetch at 0x24; addi x0,x0,9 then add x5,x0,x0 -> x5=0.
REQ-036 Fetch 0xFFFFFFFF -> halted=1 from the cycle after DECODE; mem_req stays 0 for 20 cycles; reset pulse clears halted.
REQ-037 With RISCV_MC_PERF_CNT_EN, REQ-033 program -> instret_cnt=4, cycle_cnt=16 at zero wait; without the macro both read 0.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multicycle RISC-V core: opcodes, funct fields, FSM states, ALU ops.
package riscv_mc_pkg;

   localparam logic [6:0] OpcodeReg    = 7'b0110011;
   localparam logic [6:0] OpcodeImm    = 7'b0010011;
   localparam logic [6:0] OpcodeLoad   = 7'b0000011;
   localparam logic [6:0] OpcodeStore  = 7'b0100011;
   localparam logic [6:0] OpcodeBranch = 7'b1100011;

   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3And    = 3'b111;
   localparam logic [2:0] F3Or     = 3'b110;
   localparam logic [2:0] F3Lw     = 3'b010;
   localparam logic [2:0] F3Ld     = 3'b011;
   localparam logic [2:0] F3Beq    = 3'b000;
   localparam logic [2:0] F3Bne    = 3'b001;
   localparam logic [2:0] F3Blt    = 3'b100;
   localparam logic [2:0] F3Bge    = 3'b101;

   localparam logic [6:0] F7Base = 7'b0000000;
   localparam logic [6:0] F7Sub  = 7'b0100000;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } state_e;

   typedef enum logic [1:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr
   } alu_op_e;

   // f3_mem selects lw or ld as the only legal memory width for this XLEN.
   function automatic logic is_legal(input logic [31:0] ir, input logic [2:0] f3_mem);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ir[14:12];
      f7 = ir[31:25];
      case (ir[6:0])
         OpcodeReg:
            return ((f7 == F7Base) && (f3 inside {F3AddSub, F3And, F3Or})) ||
                   ((f7 == F7Sub) && (f3 == F3AddSub));
         OpcodeImm:                return f3 == F3AddSub;
         OpcodeLoad, OpcodeStore:  return f3 == f3_mem;
         OpcodeBranch:             return f3 inside {F3Beq, F3Bne, F3Blt, F3Bge};
         default:                  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x XLEN register file, two combinational read ports, one write port; x0 hardwired to zero.
module mc_regfile #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [32];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/risc_v_multicycle_core.sv
// Multicycle RV subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) on a single req/ready memory port.
// Define RISCV_MC_PERF_CNT_EN to build the cycle and retired-instruction counters.
module risc_v_multicycle_core
   import riscv_mc_pkg::*;
#(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            retire,
   output logic            halted,
   output logic [XLEN-1:0] pc_out,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
);

   localparam logic [2:0] F3Mem = (XLEN == 64) ? F3Ld : F3Lw;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] alu_q, mdr_q;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [4:0]      rd, rs1, rs2;
   logic [XLEN-1:0] rs1_val, rs2_val, imm, alu_b, alu_res, pc_plus4;
   alu_op_e         alu_op;
   logic            is_branch, is_load, is_store, take;
   logic            rf_we, mem_req_int;

   assign opcode    = ir_q[6:0];
   assign rd        = ir_q[11:7];
   assign funct3    = ir_q[14:12];
   assign rs1       = ir_q[19:15];
   assign rs2       = ir_q[24:20];
   assign funct7    = ir_q[31:25];
   assign is_branch = (opcode == OpcodeBranch);
   assign is_load   = (opcode == OpcodeLoad);
   assign is_store  = (opcode == OpcodeStore);
   assign pc_plus4  = pc_q + XLEN'(4);

   mc_regfile #(
      .XLEN (XLEN)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (rf_we),
      .waddr  (rd),
      .wdata  (is_load ? mdr_q : alu_q),
      .raddr1 (rs1),
      .rdata1 (rs1_val),
      .raddr2 (rs2),
      .rdata2 (rs2_val)
   );

   // B-format already carries the implicit zero LSB, so it is the byte offset.
   always_comb begin
      case (opcode)
         OpcodeStore:  imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         OpcodeBranch: imm = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                              ir_q[11:8], 1'b0};
         default:      imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      endcase
   end

   always_comb begin
      alu_op = AluAdd;
      if (opcode == OpcodeReg) begin
         if (funct7 == F7Sub)        alu_op = AluSub;
         else if (funct3 == F3And)   alu_op = AluAnd;
         else if (funct3 == F3Or)    alu_op = AluOr;
      end
   end

   assign alu_b = (opcode == OpcodeReg) ? rs2_val : imm;

   always_comb begin
      case (alu_op)
         AluSub:  alu_res = rs1_val - alu_b;
         AluAnd:  alu_res = rs1_val & alu_b;
         AluOr:   alu_res = rs1_val | alu_b;
         default: alu_res = rs1_val + alu_b;
      endcase
   end

   always_comb begin
      case (funct3)
         F3Beq:   take = (rs1_val == rs2_val);
         F3Bne:   take = (rs1_val != rs2_val);
         F3Blt:   take = ($signed(rs1_val) <  $signed(rs2_val));
         F3Bge:   take = ($signed(rs1_val) >= $signed(rs2_val));
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      mem_req_int = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = pc_q;
      retire      = 1'b0;
      rf_we       = 1'b0;
      case (state_q)
         StFetch: begin
            mem_req_int = 1'b1;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            state_d = is_legal(ir_q, F3Mem) ? StExec : StHalt;
         end
         StExec: begin
            if (is_branch) begin
               retire  = 1'b1;
               pc_d    = take ? (pc_q + imm) : pc_plus4;
               state_d = StFetch;
            end else if (is_load || is_store) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            mem_req_int = 1'b1;
            mem_we      = is_store;
            mem_addr    = alu_q;
            if (mem_ready) begin
               if (is_store) begin
                  retire  = 1'b1;
                  pc_d    = pc_plus4;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            pc_d    = pc_plus4;
            state_d = StFetch;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (state_q == StFetch && mem_ready) ir_q  <= mem_rdata[31:0];
         if (state_q == StExec)               alu_q <= alu_res;
         if (state_q == StMem && mem_ready)   mdr_q <= mem_rdata;
      end
   end

   // Reset parks the FSM in FETCH; keep the request low until reset is released.
   assign mem_req   = mem_req_int & reset;
   assign mem_wdata = rs2_val;
   assign halted    = (state_q == StHalt);
   assign pc_out    = pc_q;

`ifdef RISCV_MC_PERF_CNT_EN
   logic [63:0] cycle_q, instret_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
         if (retire) instret_q <= instret_q + 64'd1;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_risc_v_multicycle_core.sv
// Directed bench for risc_v_multicycle_core: bench acts as memory, scoreboard holds expected requests.
module tb_risc_v_multicycle_core;

   logic        clk;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [63:0] mem_addr, mem_wdata, mem_rdata, pc_out, cycle_cnt, instret_cnt;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int ret_cnt = 0;
   int t0;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } xact_t;

   xact_t exp_q[$];

   risc_v_multicycle_core #(
      .XLEN     (64),
      .RESET_PC (64'd0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .retire      (retire),
      .halted      (halted),
      .pc_out      (pc_out),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change only on negedges, so retire has settled 2 time units later.
   always begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && retire === 1'b1) ret_cnt++;
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_ld(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
      return {imm, rs1, 3'b011, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_sd(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_x(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
      xact_t e;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) for mem_req and checks how many cycles it took.
   task automatic wait_req(input string tag, input int lat);
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
   endtask

   task automatic mem_xact(input int waits, input logic [63:0] rdata);
      xact_t e;
      check("scoreboard entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      for (int w = 0; w <= waits; w++) begin
         check("mem_req held", 64'(mem_req), 64'd1);
         check("mem_we", 64'(mem_we), 64'(e.we));
         check("mem_addr", mem_addr, e.addr);
         if (e.we) check("mem_wdata", mem_wdata, e.wdata);
         if (w == waits) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
         end
         tick();
      end
      mem_ready = 1'b0;
      mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
   endtask

   task automatic fetch(input logic [63:0] pc, input logic [31:0] instr, input int lat,
                        input int waits);
      wait_req("fetch", lat);
      expect_x(1'b0, pc, 64'd0);
      mem_xact(waits, {32'd0, instr});
   endtask

   task automatic store(input logic [63:0] addr, input logic [63:0] data);
      wait_req("store", 2);
      expect_x(1'b1, addr, data);
      mem_xact(0, 64'd0);
   endtask

   initial begin
      reset     = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset mem_req", 64'(mem_req), 64'd0);
         check("reset pc_out", pc_out, 64'd0);
      end
      reset = 1'b1;
      #1;
      check("release mem_req", 64'(mem_req), 64'd1);
      check("release mem_addr", mem_addr, 64'd0);
      check("release mem_we", 64'(mem_we), 64'd0);

      fetch(64'd0,  enc_i(12'd5, 5'd0, 5'd1), 0, 0);
      fetch(64'd4,  enc_i(12'd7, 5'd0, 5'd2), 3, 0);
      fetch(64'd8,  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 3, 0);
      fetch(64'd12, enc_sd(12'd8, 5'd3, 5'd0), 3, 0);
      store(64'd8, 64'd12);
      check("retire pulses", 64'(ret_cnt), 64'd4);
      check("pc after sd", pc_out, 64'd16);
`ifdef RISCV_MC_PERF_CNT_EN
      check("instret_cnt", instret_cnt, 64'd4);
      check("cycle_cnt", cycle_cnt, 64'd16);
`else
      check("instret_cnt", instret_cnt, 64'd0);
      check("cycle_cnt", cycle_cnt, 64'd0);
`endif

      t0 = cyc;
      fetch(64'd16, enc_ld(12'd8, 5'd0, 5'd4), 0, 0);
      wait_req("load", 2);
      expect_x(1'b0, 64'd8, 64'd0);
      mem_xact(3, 64'd12);
      #1;
      check("ld retire in WB", 64'(retire), 64'd1);
      check("ld cycles", 64'(cyc - t0 + 1), 64'd8);
      fetch(64'd20, enc_sd(12'd16, 5'd4, 5'd0), 1, 0);
      store(64'd16, 64'd12);

      fetch(64'd24, enc_i(12'd9, 5'd0, 5'd0), 0, 0);
      fetch(64'd28, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5), 3, 0);
      fetch(64'd32, enc_b(13'h1FF8, 5'd1, 5'd1, 3'b000), 3, 0);
      fetch(64'd24, enc_sd(12'd24, 5'd5, 5'd0), 2, 0);
      store(64'd24, 64'd0);
      fetch(64'd28, enc_i(12'hFFF, 5'd0, 5'd6), 0, 2);
      fetch(64'd32, enc_b(13'h1FF8, 5'd1, 5'd1, 3'b001), 3, 0);
      fetch(64'd36, enc_b(13'd8, 5'd1, 5'd6, 3'b100), 2, 0);
      fetch(64'd44, enc_b(13'd8, 5'd1, 5'd6, 3'b101), 2, 0);
      fetch(64'd48, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd7), 2, 0);
      fetch(64'd52, enc_r(7'h00, 5'd2, 5'd7, 3'b111, 5'd8), 3, 0);
      fetch(64'd56, enc_r(7'h00, 5'd7, 5'd1, 3'b110, 5'd9), 3, 0);
      fetch(64'd60, enc_sd(12'd32, 5'd7, 5'd0), 3, 0);
      store(64'd32, 64'hFFFF_FFFF_FFFF_FFFE);
      fetch(64'd64, enc_sd(12'd40, 5'd8, 5'd0), 0, 0);
      store(64'd40, 64'd6);
      fetch(64'd68, enc_sd(12'd48, 5'd9, 5'd0), 0, 0);
      store(64'd48, 64'hFFFF_FFFF_FFFF_FFFF);

      fetch(64'd72, 32'hFFFF_FFFF, 0, 0);
      check("halted in DECODE", 64'(halted), 64'd0);
      mem_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("halted", 64'(halted), 64'd1);
         check("halt mem_req", 64'(mem_req), 64'd0);
         check("halt retire", 64'(retire), 64'd0);
         check("halt pc frozen", pc_out, 64'd72);
      end
      mem_ready = 1'b0;

      reset = 1'b0;
      #1;
      check("reset clears halted", 64'(halted), 64'd0);
      check("reset pc_out", pc_out, 64'd0);
      check("reset mem_req", 64'(mem_req), 64'd0);
      tick();
      reset = 1'b1;
      #1;
      check("restart mem_req", 64'(mem_req), 64'd1);
      check("restart mem_addr", mem_addr, 64'd0);

      // Abandon a fetch mid-wait with reset, then re-fetch from RESET_PC.
      fetch(64'd0, enc_i(12'd3, 5'd0, 5'd1), 0, 0);
      wait_req("fetch", 3);
      tick();
      reset = 1'b0;
      #1;
      check("abort mem_req", 64'(mem_req), 64'd0);
      tick();
      reset = 1'b1;
      #1;
      check("abort restart mem_req", 64'(mem_req), 64'd1);
      check("abort restart mem_addr", mem_addr, 64'd0);
      check("abort restart pc", pc_out, 64'd0);
      check("scoreboard drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
